ip_ram_arbiter: RTL

//  Shares the single external RAM port (rd/wr/busy/address/wdata/rdata/rdata_en) between two requesters.

---
 rtl/ip_ram_arbiter_pkg.sv | 11 +
 rtl/ip_ram_arbiter_slot.sv | 36 +++
 rtl/ip_ram_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ip_ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ip_ram_arbiter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WDONE, ST_RWAIT} state_t;

  typedef logic req_id_t;

  localparam int         REQ_NUM      = 2;
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/ip_ram_arbiter_slot.sv
// One-deep request latch for a single requester: loads on a pulse when empty,
// drops pulses while occupied, and empties when the arbiter retires the transaction.
module ip_ram_arbiter_slot #(
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        wdata,
  input  logic              clear,
  output logic              valid,
  output logic              is_wr,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  // clear only ever arrives while valid is set, so it never races a load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      is_wr <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (!valid && (rd || wr)) begin
      valid <= 1'b1;
      is_wr <= wr;
      addr  <= address;
      data  <= wdata;
    end
  end

endmodule

// File: rtl/ip_ram_arbiter.sv
// Shares one RAM port between the MegaROM mapper (req0) and the auxiliary loader (req1).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise req0 has fixed priority.
module ip_ram_arbiter
  import ip_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // Requester side: rd/wr are one-cycle pulses accepted only while reqN_busy is low;
  // a pulse seen while busy is dropped. reqN_rdata is qualified by the one-cycle reqN_rdata_en.
  input  logic              req0_rd,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [7:0]        req0_wdata,
  output logic              req0_busy,
  output logic [7:0]        req0_rdata,
  output logic              req0_rdata_en,
  input  logic              req1_rd,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [7:0]        req1_wdata,
  output logic              req1_busy,
  output logic [7:0]        req1_rdata,
  output logic              req1_rdata_en,
  output logic              rd,
  output logic              wr,
  input  logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        wdata,
  input  logic [7:0]        rdata,
  input  logic              rdata_en,
  output state_t            dbg_state
);

  logic [REQ_NUM-1:0] slot_valid;
  logic [REQ_NUM-1:0] slot_wr;
  logic [REQ_NUM-1:0] slot_clear;
  logic [ADDR_W-1:0]  slot_addr [REQ_NUM];
  logic [7:0]         slot_data [REQ_NUM];

  ip_ram_arbiter_slot #(.ADDR_W(ADDR_W)) u_slot0 (
    .clk(clk), .reset(reset), .rd(req0_rd), .wr(req0_wr),
    .address(req0_address), .wdata(req0_wdata), .clear(slot_clear[0]),
    .valid(slot_valid[0]), .is_wr(slot_wr[0]), .addr(slot_addr[0]), .data(slot_data[0])
  );

  ip_ram_arbiter_slot #(.ADDR_W(ADDR_W)) u_slot1 (
    .clk(clk), .reset(reset), .rd(req1_rd), .wr(req1_wr),
    .address(req1_address), .wdata(req1_wdata), .clear(slot_clear[1]),
    .valid(slot_valid[1]), .is_wr(slot_wr[1]), .addr(slot_addr[1]), .data(slot_data[1])
  );

  state_t             state, state_next;
  req_id_t            owner, grant_id;
  logic               do_grant, do_ret;
  logic [7:0]         ret_data;
  logic [7:0]         timer, timer_inc;
  logic [7:0]         rdata_q [REQ_NUM];
  logic [REQ_NUM-1:0] rdata_en_q;
`ifdef ARB_ROUND_ROBIN_EN
  req_id_t            last_grant;
`endif

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_ret     = 1'b0;
    ret_data   = rdata;
    slot_clear = '0;
    timer_inc  = (timer == 8'hFF) ? timer : timer + 8'd1;

    if (&slot_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_id = ~last_grant;
`else
      grant_id = 1'b0;
`endif
    end else begin
      grant_id = ~slot_valid[0];
    end

    case (state)
      ST_IDLE: begin
        if (!busy && |slot_valid) begin
          do_grant   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = slot_wr[owner] ? ST_WDONE : ST_RWAIT;
      ST_WDONE: begin
        slot_clear[owner] = 1'b1;
        state_next        = ST_IDLE;
      end
      ST_RWAIT: begin
        // timeout fires on the cycle the wait count would reach RD_TIMEOUT
        if (rdata_en) begin
          do_ret = 1'b1;
        end else if (timer_inc == 8'(RD_TIMEOUT)) begin
          do_ret   = 1'b1;
          ret_data = TIMEOUT_DATA;
        end
        if (do_ret) begin
          slot_clear[owner] = 1'b1;
          state_next        = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      timer      <= '0;
      address    <= '0;
      wdata      <= '0;
      rdata_en_q <= '0;
      for (int i = 0; i < REQ_NUM; i++) rdata_q[i] <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state      <= state_next;
      rdata_en_q <= '0;
      if (do_grant) begin
        owner   <= grant_id;
        address <= slot_addr[grant_id];
        wdata   <= slot_data[grant_id];
`ifdef ARB_ROUND_ROBIN_EN
        last_grant <= grant_id;
`endif
      end
      if (state == ST_ISSUE)      timer <= '0;
      else if (state == ST_RWAIT) timer <= timer_inc;
      if (do_ret) begin
        rdata_en_q[owner] <= 1'b1;
        rdata_q[owner]    <= ret_data;
      end
    end
  end

  assign rd            = (state == ST_ISSUE) && !slot_wr[owner];
  assign wr            = (state == ST_ISSUE) &&  slot_wr[owner];
  assign req0_busy     = slot_valid[0];
  assign req1_busy     = slot_valid[1];
  assign req0_rdata    = rdata_q[0];
  assign req1_rdata    = rdata_q[1];
  assign req0_rdata_en = rdata_en_q[0];
  assign req1_rdata_en = rdata_en_q[1];
  assign dbg_state     = state;

endmodule
